// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/halt control unit.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W     = 5;
   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned INSTR_W   = 32;

   localparam logic [REG_W-1:0]   ZERO_REG  = REG_W'(0);
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic pipe_hlt;
   } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the controller (slave).
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic [REG_W-1:0] rs1_ID;
   logic [REG_W-1:0] rs2_ID;
   logic             rs1_used_ID;
   logic             rs2_used_ID;
   logic [REG_W-1:0] rd_EX;
   logic             mem_rd_EX;
   logic             br_taken_EX;
   logic             hlt_ID;
   logic             imem_rdy;
   logic             dmem_rdy;

   logic             pc_stall;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             pipe_hlt;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_rd_EX,
             br_taken_EX, hlt_ID, imem_rdy, dmem_rdy,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hlt,
             halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_rd_EX,
             br_taken_EX, hlt_ID, imem_rdy, dmem_rdy,
      output pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hlt,
             halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt control for the 5-stage core, with halt drain sequencing and debug counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYC = 3,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

   state_e         state, state_nxt;
   logic [DW-1:0]  drain, drain_nxt;
   hz_ctrl_t       ctl;
   logic           load_use;
   logic           stall_inc;
   logic           flush_inc;
   logic [CNT_W-1:0] stall_val;
   logic [CNT_W-1:0] flush_val;

   assign load_use = bus.mem_rd_EX && (bus.rd_EX != ZERO_REG) &&
                     ((bus.rs1_used_ID && (bus.rs1_ID == bus.rd_EX)) ||
                      (bus.rs2_used_ID && (bus.rs2_ID == bus.rd_EX)));

   // Next-state and control decode; memory wait outranks everything, then branch.
   always_comb begin
      ctl       = '0;
      state_nxt = state;
      drain_nxt = drain;
      case (state)
         RUN: begin
            if (!bus.dmem_rdy) begin
               ctl.pipe_hlt = 1'b1;
            end else if (bus.br_taken_EX) begin
               ctl.if_id_flush = 1'b1;
               ctl.id_ex_flush = 1'b1;
            end else if (load_use) begin
               ctl.pc_stall    = 1'b1;
               ctl.if_id_stall = 1'b1;
               ctl.id_ex_flush = 1'b1;
            end else if (bus.hlt_ID) begin
               ctl.pc_stall    = 1'b1;
               ctl.if_id_flush = 1'b1;
               state_nxt       = DRAIN;
               drain_nxt       = DW'(DRAIN_CYC);
            end else if (!bus.imem_rdy) begin
               ctl.pc_stall    = 1'b1;
               ctl.if_id_flush = 1'b1;
            end
         end
         DRAIN: begin
            if (!bus.dmem_rdy) begin
               ctl.pipe_hlt = 1'b1;
            end else if (bus.br_taken_EX) begin
               ctl.if_id_flush = 1'b1;
               ctl.id_ex_flush = 1'b1;
               state_nxt       = RUN;
               drain_nxt       = '0;
            end else begin
               ctl.pc_stall    = 1'b1;
               ctl.if_id_flush = 1'b1;
               drain_nxt       = drain - DW'(1);
               if (drain <= DW'(1)) begin
                  state_nxt = HALTED;
               end
            end
         end
         HALTED: begin
            ctl.pc_stall    = 1'b1;
            ctl.if_id_stall = 1'b1;
            ctl.pipe_hlt    = 1'b1;
         end
         default: begin
            state_nxt = RUN;
            drain_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         drain <= '0;
      end else begin
         state <= state_nxt;
         drain <= drain_nxt;
      end
   end

   // Controls are forced low while reset is held, independent of inputs.
   assign bus.pc_stall    = rst_n && ctl.pc_stall;
   assign bus.if_id_stall = rst_n && ctl.if_id_stall;
   assign bus.if_id_flush = rst_n && ctl.if_id_flush;
   assign bus.id_ex_flush = rst_n && ctl.id_ex_flush;
   assign bus.pipe_hlt    = rst_n && ctl.pipe_hlt;
   assign bus.halted      = rst_n && (state == HALTED);

   assign stall_inc = (ctl.pc_stall || ctl.pipe_hlt) && (state != HALTED);
   assign flush_inc = ctl.if_id_flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .cnt   (stall_val)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .cnt   (flush_val)
   );

   assign bus.stall_cnt = stall_val;
   assign bus.flush_cnt = flush_val;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int DRAIN_CYC = 3;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
   // Packed order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hlt, halted}
   localparam logic [5:0] C_IDLE   = 6'b000000;
   localparam logic [5:0] C_MWAIT  = 6'b000010;
   localparam logic [5:0] C_BRANCH = 6'b001100;
   localparam logic [5:0] C_LDUSE  = 6'b110100;
   localparam logic [5:0] C_FETCHK = 6'b101000;
   localparam logic [5:0] C_HALT   = 6'b110011;

   logic clk;
   logic rst_n;
   logic [4:0] rs1, rs2, rd;
   logic u1, u2, mem_rd, br, hlt, imem, dmem;

   logic [5:0]  obs, expv;
   logic [15:0] obs_stall, obs_flush, exp_stall, exp_flush;

   int m_mode, m_left, m_stall, m_flush;
   int checks, failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

   assign bus.rs1_ID      = rs1;
   assign bus.rs2_ID      = rs2;
   assign bus.rs1_used_ID = u1;
   assign bus.rs2_used_ID = u2;
   assign bus.rd_EX       = rd;
   assign bus.mem_rd_EX   = mem_rd;
   assign bus.br_taken_EX = br;
   assign bus.hlt_ID      = hlt;
   assign bus.imem_rdy    = imem;
   assign bus.dmem_rdy    = dmem;

   pipe_hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   function automatic logic is_load_use();
      return mem_rd && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   // What the controls must be this cycle, from the priority rules.
   function automatic logic [5:0] model_ctl();
      if (m_mode == M_HALT) return C_HALT;
      if (!dmem) return C_MWAIT;
      if (br) return C_BRANCH;
      if (m_mode == M_DRAIN) return C_FETCHK;
      if (is_load_use()) return C_LDUSE;
      if (hlt || !imem) return C_FETCHK;
      return C_IDLE;
   endfunction

   task automatic model_advance(input logic [5:0] c);
      if (m_mode != M_HALT && (c[5] || c[1])) m_stall++;
      if (c[3]) m_flush++;
      if (m_mode == M_RUN) begin
         if (dmem && !br && !is_load_use() && hlt) begin
            m_mode = M_DRAIN;
            m_left = DRAIN_CYC;
         end
      end else if (m_mode == M_DRAIN && dmem) begin
         if (br) begin
            m_mode = M_RUN;
            m_left = 0;
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_HALT;
         end
      end
   endtask

   // Runs one clock: captures outputs mid-cycle, records expectations, advances model.
   task automatic step();
      @(negedge clk);
      obs       = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
                   bus.id_ex_flush, bus.pipe_hlt, bus.halted};
      obs_stall = bus.stall_cnt;
      obs_flush = bus.flush_cnt;
      expv      = model_ctl();
      exp_stall = sat16(m_stall);
      exp_flush = sat16(m_flush);
      model_advance(expv);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
      u1 = 1'b0; u2 = 1'b0; mem_rd = 1'b0; br = 1'b0; hlt = 1'b0;
      imem = 1'b1; dmem = 1'b1;
   endtask

   task automatic randomize_inputs(input bit allow_hlt);
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      rd     = 5'($urandom_range(0, 3));
      u1     = 1'($urandom_range(0, 1));
      u2     = 1'($urandom_range(0, 1));
      mem_rd = 1'($urandom_range(0, 1));
      br     = ($urandom_range(0, 7) == 0);
      hlt    = allow_hlt && ($urandom_range(0, 11) == 0);
      imem   = ($urandom_range(0, 3) != 0);
      dmem   = ($urandom_range(0, 7) != 0);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_mode = M_RUN; m_left = 0; m_stall = 0; m_flush = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      imem = 1'b0; dmem = 1'b0; br = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      obs = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
             bus.id_ex_flush, bus.pipe_hlt, bus.halted};
      checks++;
      if (obs !== C_IDLE) begin
         failures++;
         $display("FAIL reset_ctl got=%b want=%b", obs, C_IDLE);
      end
      checks++;
      if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%h/%h want=0/0", bus.stall_cnt, bus.flush_cnt);
      end
      do_reset();
      step();
      checks++;
      if (obs !== C_IDLE || obs_stall !== 16'd0) begin
         failures++;
         $display("FAIL reset_release got=%b/%h want=%b/0", obs, obs_stall, C_IDLE);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      mem_rd = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1;
      step();
      checks++;
      if (obs !== C_LDUSE) begin
         failures++;
         $display("FAIL load_use_hit got=%b want=%b", obs, C_LDUSE);
      end
      idle();
      step();
      checks++;
      if (obs !== C_IDLE || obs_stall !== 16'd1) begin
         failures++;
         $display("FAIL load_use_once got=%b/%0d want=%b/1", obs, obs_stall, C_IDLE);
      end
      mem_rd = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1;
      step();
      checks++;
      if (obs !== C_IDLE) begin
         failures++;
         $display("FAIL load_use_r0 got=%b want=%b", obs, C_IDLE);
      end
      for (int i = 0; i < 60; i++) begin
         randomize_inputs(1'b0);
         step();
         checks++;
         if (obs !== expv || obs_stall !== exp_stall || obs_flush !== exp_flush) begin
            failures++;
            $display("FAIL run_random[%0d] got=%b/%h/%h want=%b/%h/%h",
                     i, obs, obs_stall, obs_flush, expv, exp_stall, exp_flush);
         end
      end
   endtask

   task automatic test_branch_priority();
      do_reset();
      br = 1'b1; hlt = 1'b1; mem_rd = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b1;
      step();
      checks++;
      if (obs !== C_BRANCH) begin
         failures++;
         $display("FAIL branch_prio got=%b want=%b", obs, C_BRANCH);
      end
      idle();
      step();
      checks++;
      if (obs !== C_IDLE || obs_flush !== 16'd1 || obs_stall !== 16'd0) begin
         failures++;
         $display("FAIL branch_after got=%b/%0d/%0d want=%b/1/0", obs, obs_flush, obs_stall, C_IDLE);
      end
   endtask

   task automatic test_halt_seq();
      logic [15:0] frozen_s, frozen_f;
      do_reset();
      hlt = 1'b1;
      step();
      checks++;
      if (obs !== C_FETCHK) begin
         failures++;
         $display("FAIL halt_enter got=%b want=%b", obs, C_FETCHK);
      end
      idle();
      for (int k = 1; k <= DRAIN_CYC; k++) begin
         step();
         checks++;
         if (obs !== C_FETCHK) begin
            failures++;
            $display("FAIL halt_drain[%0d] got=%b want=%b", k, obs, C_FETCHK);
         end
      end
      step();
      checks++;
      if (obs !== C_HALT) begin
         failures++;
         $display("FAIL halt_reached got=%b want=%b", obs, C_HALT);
      end
      frozen_s = obs_stall;
      frozen_f = obs_flush;
      for (int i = 0; i < 20; i++) begin
         randomize_inputs(1'b1);
         step();
         checks++;
         if (obs !== C_HALT || obs_stall !== frozen_s || obs_flush !== frozen_f ||
             obs_stall !== exp_stall) begin
            failures++;
            $display("FAIL halt_hold[%0d] got=%b/%h/%h want=%b/%h/%h",
                     i, obs, obs_stall, obs_flush, C_HALT, frozen_s, frozen_f);
         end
      end
   endtask

   task automatic test_halt_squash();
      bit saw_halt;
      do_reset();
      hlt = 1'b1;
      step();
      idle();
      step();
      br = 1'b1;
      step();
      checks++;
      if (obs !== C_BRANCH) begin
         failures++;
         $display("FAIL squash_flush got=%b want=%b", obs, C_BRANCH);
      end
      idle();
      saw_halt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (obs[0]) saw_halt = 1'b1;
      end
      checks++;
      if (saw_halt || obs !== C_IDLE) begin
         failures++;
         $display("FAIL squash_run got=%b halted_seen=%0d want=%b halted_seen=0", obs, saw_halt, C_IDLE);
      end
   endtask

   task automatic test_mem_wait();
      logic [15:0] s0;
      int halt_at;
      do_reset();
      mem_rd = 1'b1; rd = 5'd9; rs1 = 5'd9; u1 = 1'b1; dmem = 1'b0;
      step();
      s0 = obs_stall;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs !== C_MWAIT) begin
            failures++;
            $display("FAIL mwait_lu[%0d] got=%b want=%b", i, obs, C_MWAIT);
         end
         if (i < 3) step();
      end
      dmem = 1'b1;
      step();
      checks++;
      if (obs !== C_LDUSE || obs_stall !== s0 + 16'd4) begin
         failures++;
         $display("FAIL mwait_lu_resume got=%b/%0d want=%b/%0d", obs, obs_stall, C_LDUSE, s0 + 16'd4);
      end
      do_reset();
      hlt = 1'b1;
      step();
      idle();
      halt_at = 0;
      for (int k = 1; k <= 20 && halt_at == 0; k++) begin
         dmem = !(k >= 2 && k <= 5);
         step();
         checks++;
         if (obs !== expv) begin
            failures++;
            $display("FAIL mwait_drain[%0d] got=%b want=%b", k, obs, expv);
         end
         if (obs[0]) halt_at = k;
      end
      checks++;
      if (halt_at != DRAIN_CYC + 1 + 4) begin
         failures++;
         $display("FAIL mwait_halt_delay got=%0d want=%0d", halt_at, DRAIN_CYC + 5);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      hlt = 1'b1;
      step();
      idle();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      obs = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
             bus.id_ex_flush, bus.pipe_hlt, bus.halted};
      checks++;
      if (obs !== C_IDLE || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
         failures++;
         $display("FAIL async_reset got=%b/%h/%h want=%b/0/0", obs, bus.stall_cnt, bus.flush_cnt, C_IDLE);
      end
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs !== C_IDLE) begin
            failures++;
            $display("FAIL async_reset_run[%0d] got=%b want=%b", i, obs, C_IDLE);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      imem = 1'b0;
      for (int i = 0; i < 65536 + 5; i++) step();
      idle();
      step();
      checks++;
      if (obs_stall !== 16'hFFFF || obs_flush !== 16'hFFFF || exp_stall !== 16'hFFFF) begin
         failures++;
         $display("FAIL saturation got=%h/%h want=ffff/ffff", obs_stall, obs_flush);
      end
   endtask

   task automatic test_random();
      int halted_for;
      do_reset();
      halted_for = 0;
      for (int i = 0; i < 400; i++) begin
         randomize_inputs(1'b1);
         step();
         checks++;
         if (obs !== expv || obs_stall !== exp_stall || obs_flush !== exp_flush) begin
            failures++;
            $display("FAIL random[%0d] got=%b/%h/%h want=%b/%h/%h",
                     i, obs, obs_stall, obs_flush, expv, exp_stall, exp_flush);
         end
         halted_for = (m_mode == M_HALT) ? halted_for + 1 : 0;
         if (halted_for > 6) begin
            do_reset();
            halted_for = 0;
         end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      m_mode = M_RUN; m_left = 0; m_stall = 0; m_flush = 0;
      rst_n = 1'b0;
      idle();
      test_reset();
      test_load_use();
      test_branch_priority();
      test_halt_seq();
      test_halt_squash();
      test_mem_wait();
      test_async_reset();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
